// File: rtl/activation_unit_if.sv
// Bus bundle between the activation stage and its control/producer/consumer.
// N is the total element count (CHANNELS*MAP_WIDTH*MAP_WIDTH) of the attached unit.
interface activation_unit_if #(
  parameter int N      = 16,
  parameter int DATA_W = 32
);
  localparam int ZW = $clog2(N + 1);

  logic                     start;
  logic [1:0]               mode;
  logic [4:0]               leak_shift;
  logic signed [DATA_W-1:0] clip_val;
  logic [N*DATA_W-1:0]      input_map;
  logic [N*DATA_W-1:0]      output_map;
  logic                     busy;
  logic                     done;
  logic [ZW-1:0]            zero_count;

  modport master (
    output start, mode, leak_shift, clip_val, input_map,
    input  output_map, busy, done, zero_count
  );

  modport slave (
    input  start, mode, leak_shift, clip_val, input_map,
    output output_map, busy, done, zero_count
  );
endinterface

// File: rtl/activation_unit.sv
// Multi-lane activation stage: walks a flattened feature map LANES elements per
// cycle, applying ReLU / leaky ReLU / clipped ReLU / identity and counting zeros.
module activation_unit #(
  parameter int MAP_WIDTH = 4,
  parameter int CHANNELS  = 1,
  parameter int DATA_W    = 32,
  parameter int LANES     = 1
) (
  input  logic             clk,
  input  logic             reset,
  activation_unit_if.slave bus
);
  localparam int N  = CHANNELS * MAP_WIDTH * MAP_WIDTH;
  localparam int G  = N / LANES;
  localparam int GW = (G > 1) ? $clog2(G) : 1;
  localparam int ZW = $clog2(N + 1);

  generate
    if (N % LANES != 0) begin : g_bad_lanes
      $error("activation_unit: element count must be divisible by LANES");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                   state_q, state_d;
  logic [GW-1:0]            g_q, g_d;
  logic [1:0]               mode_q, mode_d;
  logic [4:0]               shift_q, shift_d;
  logic signed [DATA_W-1:0] clip_q, clip_d;
  logic [N*DATA_W-1:0]      out_q, out_d;
  logic [ZW-1:0]            zc_q, zc_d;

  logic [31:0]              elem_base;
  logic [LANES*DATA_W-1:0]  lane_out;
  logic [LANES-1:0]         lane_zero;
  logic [ZW-1:0]            zeros_in_group;
  logic                     busy_o, done_o;

  assign elem_base = 32'(g_q) * 32'(LANES);

  // One activation datapath per lane, all fed from the current group.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic signed [DATA_W-1:0] x, y;

      assign x = bus.input_map[(elem_base + 32'(gi)) * DATA_W +: DATA_W];

      always_comb begin
        y = x;
        case (mode_q)
          2'd0: y = (x > 0) ? x : '0;
          2'd1: y = x[DATA_W-1] ? (x >>> shift_q) : x;
          2'd2: begin
            if (clip_q[DATA_W-1] || x[DATA_W-1]) y = '0;
            else if (x > clip_q)                 y = clip_q;
            else                                 y = x;
          end
          default: y = x;
        endcase
      end

      assign lane_out[gi*DATA_W +: DATA_W] = y;
      assign lane_zero[gi]                 = (y == '0);
    end
  endgenerate

  always_comb begin
    zeros_in_group = '0;
    for (int l = 0; l < LANES; l++) begin
      zeros_in_group = zeros_in_group + ZW'(lane_zero[l]);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      g_q     <= '0;
      mode_q  <= '0;
      shift_q <= '0;
      clip_q  <= '0;
      out_q   <= '0;
      zc_q    <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      mode_q  <= mode_d;
      shift_q <= shift_d;
      clip_q  <= clip_d;
      out_q   <= out_d;
      zc_q    <= zc_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    mode_d  = mode_q;
    shift_d = shift_q;
    clip_d  = clip_q;
    out_d   = out_q;
    zc_d    = zc_q;
    case (state_q)
      S_RUN: begin
        for (int l = 0; l < LANES; l++) begin
          out_d[(elem_base + 32'(l)) * DATA_W +: DATA_W] = lane_out[l*DATA_W +: DATA_W];
        end
        zc_d = zc_q + zeros_in_group;
        if (g_q == GW'(G - 1)) begin
          state_d = S_DONE;
        end else begin
          g_d = g_q + 1'b1;
        end
      end
      default: begin
        // Parameters are captured only here, so a start seen mid-run has no effect.
        if (bus.start) begin
          state_d = S_RUN;
          g_d     = '0;
          zc_d    = '0;
          mode_d  = bus.mode;
          shift_d = bus.leak_shift;
          clip_d  = bus.clip_val;
        end
      end
    endcase
  end

  // Outputs
  always_comb begin
    busy_o = 1'b0;
    done_o = 1'b0;
    case (state_q)
      S_RUN:   busy_o = 1'b1;
      S_DONE:  done_o = 1'b1;
      default: ;
    endcase
  end

  assign bus.busy       = busy_o;
  assign bus.done       = done_o;
  assign bus.output_map = out_q;
  assign bus.zero_count = zc_q;

endmodule
